fifo_rd_ctrl: RTL and testbench

Read-side controller for the synchronous FIFO: the consumer end of the write pointer produced by the FIFO's write-side counter. It owns the read pointer, addresses the storage array, and presents words on a registered valid/ready output stage (show-ahead). Write side, storage and this block share one clock. The write pointer carries one extra wrap bit so full and empty can be told apart.

---
 rtl/fifo_rd_ctrl.sv | 113 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a synchronous FIFO: owns the read pointer and drives a
// registered show-ahead valid/ready output stage fed from the storage array.
module fifo_rd_ctrl #(
  parameter int unsigned K = 3,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K:0]   wr_ptr,
  input  logic [W-1:0] mem_rdata,
  input  logic         out_ready,
  input  logic         flush,
  output logic [K-1:0] mem_raddr,
  output logic [K:0]   rd_ptr,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         empty,
  output logic [K:0]   count,
  output logic         ptr_err
);

  localparam int unsigned Depth = 2 ** K;
  localparam logic [K:0] DepthCnt = (K+1)'(Depth);

  typedef enum logic [0:0] {StFree, StOccupied} state_e;

  state_e         state_q, state_d;
  logic [K:0]     rd_ptr_q, rd_ptr_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           ptr_err_q, ptr_err_d;
  logic           load;
  logic           overrun;

  // Occupancy is taken modulo 2^(K+1); the wrap bit keeps full distinct from empty.
  always_comb begin
    count   = wr_ptr - rd_ptr_q;
    empty   = (wr_ptr == rd_ptr_q);
    overrun = (count > DepthCnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFree;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush beats load, load beats a plain consume; a load may coincide with a consume.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (flush) begin
      state_d = StFree;
    end else begin
      unique case (state_q)
        StFree: begin
          if (!empty) begin
            load    = 1'b1;
            state_d = StOccupied;
          end
        end
        StOccupied: begin
          if (out_ready) begin
            if (!empty) begin
              load    = 1'b1;
              state_d = StOccupied;
            end else begin
              state_d = StFree;
            end
          end
        end
        default: state_d = StFree;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == StOccupied);
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    out_data_d = out_data_q;
    if (flush) begin
      rd_ptr_d = wr_ptr;
    end else if (load) begin
      rd_ptr_d   = rd_ptr_q + (K+1)'(1);
      out_data_d = mem_rdata;
    end
    ptr_err_d = ptr_err_q | overrun;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      out_data_q <= '0;
      ptr_err_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      out_data_q <= out_data_d;
      ptr_err_q  <= ptr_err_d;
    end
  end

  always_comb begin
    rd_ptr    = rd_ptr_q;
    mem_raddr = rd_ptr_q[K-1:0];
    out_data  = out_data_q;
    ptr_err   = ptr_err_q;
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: models the write side and storage, scoreboards the
// words written against the words handed out on the valid/ready stage.
module tb_fifo_rd_ctrl;

  localparam int unsigned K = 3;
  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic [K:0]   wr_ptr;
  logic [W-1:0] mem_rdata;
  logic         out_ready;
  logic         flush;
  logic [K-1:0] mem_raddr;
  logic [K:0]   rd_ptr;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         empty;
  logic [K:0]   count;
  logic         ptr_err;

  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         wr_jump;
  logic [K:0]   wr_jump_val;
  logic [W-1:0] mem [2**K];

  logic [W-1:0] exp_q [$];
  int           n_checks;
  int           n_errors;
  int           n_consumed;

  fifo_rd_ctrl #(.K(K), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_ptr    (wr_ptr),
    .mem_rdata (mem_rdata),
    .out_ready (out_ready),
    .flush     (flush),
    .mem_raddr (mem_raddr),
    .rd_ptr    (rd_ptr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .empty     (empty),
    .count     (count),
    .ptr_err   (ptr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-side counter and storage array sharing the DUT clock and reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_jump) begin
      wr_ptr <= wr_jump_val;
    end else if (wr_en) begin
      mem[wr_ptr[K-1:0]] <= wr_data;
      wr_ptr             <= wr_ptr + 1'b1;
    end
  end

  assign mem_rdata = mem[mem_raddr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle; inputs only move just after a rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) begin
        exp_q.delete();
      end else if (out_valid && out_ready) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          check_eq("sb_nonempty", exp_q.size(), 1);
        end else begin
          check_eq("sb_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_data   = '0;
    wr_jump   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    tick(2);
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick(1);
    wr_en = 1'b0;
  endtask

  initial begin
    int consumed_before;
    n_checks   = 0;
    n_errors   = 0;
    n_consumed = 0;
    wr_jump_val = '0;
    reset_dut();

    // Asynchronous reset with a word held in the output register.
    write_word(8'h3C);
    tick(2);
    check_eq("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_rd_ptr", rd_ptr, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_count", count, 0);
    check_eq("rst_raddr", mem_raddr, 0);
    check_eq("rst_ptr_err", ptr_err, 0);
    reset_dut();

    // Single word, stalled for five cycles, then consumed.
    write_word(8'hA5);
    check_eq("single_empty", empty, 0);
    check_eq("single_valid_lat", out_valid, 0);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_data", out_data, 8'hA5);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    check_eq("single_done_valid", out_valid, 0);
    check_eq("single_done_empty", empty, 1);
    check_eq("single_sb_drained", exp_q.size(), 0);

    // Streaming 20 words through an 8-deep store, wrapping the pointer.
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      write_word(W'(i));
      if (i >= 1) check_eq("stream_valid", out_valid, 1);
    end
    tick(1);
    check_eq("stream_last_valid", out_valid, 1);
    tick(1);
    check_eq("stream_end_valid", out_valid, 0);
    tick(1);
    check_eq("stream_rd_ptr", rd_ptr, 5'b10100 % 16);
    check_eq("stream_raddr", mem_raddr, 4);
    check_eq("stream_count", count, 0);
    check_eq("stream_sb_drained", exp_q.size(), 0);

    // Full buffer: eight in storage plus one in the output register.
    reset_dut();
    for (int i = 0; i < 8; i++) write_word(8'h40 + W'(i));
    check_eq("full_count7", count, 7);
    check_eq("full_rd_ptr", rd_ptr, 1);
    tick(2);
    check_eq("full_rd_hold", rd_ptr, 1);
    check_eq("full_data_hold", out_data, 8'h40);
    write_word(8'h48);
    check_eq("full_count8", count, 8);
    check_eq("full_wr_ptr", wr_ptr, 4'b1001);
    tick(1);
    check_eq("full_no_err", ptr_err, 0);
    consumed_before = n_consumed;
    out_ready = 1'b1;
    tick(12);
    check_eq("full_drained_n", n_consumed - consumed_before, 9);
    check_eq("full_sb_drained", exp_q.size(), 0);
    check_eq("full_empty", empty, 1);

    // Flush with a handshake pending in the same cycle.
    reset_dut();
    for (int i = 0; i < 5; i++) write_word(8'h80 + W'(i));
    check_eq("flush_pre_count", count, 4);
    check_eq("flush_pre_valid", out_valid, 1);
    consumed_before = n_consumed;
    flush     = 1'b1;
    out_ready = 1'b1;
    tick(1);
    flush = 1'b0;
    check_eq("flush_ptr_eq", rd_ptr, wr_ptr);
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_count", count, 0);
    check_eq("flush_data_kept", out_data, 8'h80);
    tick(2);
    check_eq("flush_no_consume", n_consumed - consumed_before, 0);
    check_eq("flush_stay_idle", out_valid, 0);

    // Overrun: write side jumps nine words ahead.
    reset_dut();
    wr_jump_val = 4'd9;
    wr_jump     = 1'b1;
    tick(1);
    wr_jump = 1'b0;
    check_eq("ovr_count", count, 9);
    check_eq("ovr_err_latency", ptr_err, 0);
    tick(1);
    check_eq("ovr_err_set", ptr_err, 1);
    check_eq("ovr_still_loads", rd_ptr, 1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check_eq("ovr_flush_count", count, 0);
    check_eq("ovr_err_sticky", ptr_err, 1);
    tick(2);
    check_eq("ovr_err_sticky2", ptr_err, 1);
    rst = 1'b1;
    #1;
    check_eq("ovr_err_rst", ptr_err, 0);
    reset_dut();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
